gray_timer_seq: RTL and testbench

//   Sequencer directly upstream of gray_timer. Latches a tick limit and a repeat count,

---
 rtl/gray_timer_seq.sv | 118 +++++++++++
 tb/tb_gray_timer_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gray_timer_seq.sv
// rtl/gray_timer_seq.sv - sequencer that arms gray_timer for N back-to-back runs and reports the result
module gray_timer_seq #(
    parameter int SIZE    = 8,
    parameter int RSIZE   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              Abort,
    input  logic [SIZE-1:0]   Limit_in,
    input  logic [RSIZE-1:0]  Repeat_in,
    input  logic              Tmr_Int,
    output logic              Tmr_Rst_n,
    output logic [SIZE-1:0]   Tmr_Limit,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [RSIZE-1:0]  Run_cnt,
    output logic [SIZE+1:0]   Last_cyc
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, GAP} state_t;

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYC - 1);
    // A healthy run ends by 2^SIZE+1 RUN edges, so this leaves margin before flagging a dead timer.
    localparam logic [SIZE+1:0] TMO      = (SIZE+2)'((1 << SIZE) + 4);

    state_t            state;
    logic [RSIZE-1:0]  rep;
    logic [SIZE+1:0]   cyc;
    logic [GW-1:0]     gap_cnt;
    logic [SIZE+1:0]   cyc_nxt;
    logic [RSIZE-1:0]  run_nxt;

    assign cyc_nxt = cyc + 1'b1;
    assign run_nxt = Run_cnt + 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            rep       <= '0;
            cyc       <= '0;
            gap_cnt   <= '0;
            Tmr_Rst_n <= 1'b0;
            Tmr_Limit <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            Run_cnt   <= '0;
            Last_cyc  <= '0;
        end else begin
            Done <= 1'b0;
            if (Abort && state != IDLE) begin
                state     <= IDLE;
                Busy      <= 1'b0;
                Tmr_Rst_n <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        Tmr_Rst_n <= 1'b0;
                        if (Start && !Abort) begin
                            state     <= ARM;
                            Busy      <= 1'b1;
                            Tmr_Limit <= Limit_in;
                            rep       <= (Repeat_in == '0) ? RSIZE'(1) : Repeat_in;
                            Run_cnt   <= '0;
                            Err       <= 1'b0;
                        end
                    end
                    ARM: begin
                        state     <= RUN;
                        Tmr_Rst_n <= 1'b1;
                        cyc       <= '0;
                    end
                    RUN: begin
                        if (Tmr_Int) begin
                            Last_cyc  <= cyc_nxt;
                            Run_cnt   <= run_nxt;
                            Tmr_Rst_n <= 1'b0;
                            if (run_nxt == rep) begin
                                state <= IDLE;
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else if (cyc_nxt == TMO) begin
                            Err       <= 1'b1;
                            Tmr_Rst_n <= 1'b0;
                            state     <= IDLE;
                            Busy      <= 1'b0;
                        end else begin
                            cyc <= cyc_nxt;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state     <= RUN;
                            Tmr_Rst_n <= 1'b1;
                            cyc       <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        Busy      <= 1'b0;
                        Tmr_Rst_n <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_timer_seq.sv
// tb/tb_gray_timer_seq.sv - scoreboard bench for gray_timer_seq with a behavioural gray_timer
module tb_gray_timer_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] limit_in = '0;
    logic [3:0] repeat_in = '0;
    logic       tmr_int;
    logic       tmr_rst_n;
    logic [7:0] tmr_limit;
    logic       busy, done, err;
    logic [3:0] run_cnt;
    logic [9:0] last_cyc;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;
    bit force_low = 1'b0;
    int tcnt = 0;

    typedef struct {int edge_at; int last; int runs;} exp_t;
    exp_t sb[$];

    gray_timer_seq #(.SIZE(8), .RSIZE(4), .GAP_CYC(2)) dut (
        .Clk(clk), .Rst_n(rst_n), .Start(start), .Abort(abort),
        .Limit_in(limit_in), .Repeat_in(repeat_in), .Tmr_Int(tmr_int),
        .Tmr_Rst_n(tmr_rst_n), .Tmr_Limit(tmr_limit), .Busy(busy), .Done(done),
        .Err(err), .Run_cnt(run_cnt), .Last_cyc(last_cyc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Timer stand-in: Int is seen on the (L+2)-th edge after its reset is released.
    always @(posedge clk or negedge tmr_rst_n) begin
        if (!tmr_rst_n) tcnt <= 0;
        else if (tcnt < 1023) tcnt <= tcnt + 1;
    end
    assign tmr_int = tmr_rst_n && !force_low && (tcnt >= int'(tmr_limit) + 1);

    task automatic expect_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                expect_eq("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                expect_eq("done_edge", edge_no, e.edge_at);
                expect_eq("done_last_cyc", int'(last_cyc), e.last);
                expect_eq("done_run_cnt", int'(run_cnt), e.runs);
                expect_eq("done_busy", int'(busy), 0);
            end
        end
    end

    int  low_len = 0;
    bit  seen_high = 1'b0;
    bit  prev_rst = 1'b0;
    always @(negedge clk) begin
        if (!busy) begin
            low_len   <= 0;
            seen_high <= 1'b0;
        end else if (!tmr_rst_n) begin
            low_len <= low_len + 1;
        end else begin
            if (!prev_rst && seen_high) expect_eq("gap_len", low_len, 2);
            seen_high <= 1'b1;
            low_len   <= 0;
        end
        prev_rst <= tmr_rst_n;
    end

    task automatic start_seq(input int l, input int r, input bit push);
        int rr;
        rr = (r == 0) ? 1 : r;
        limit_in  = 8'(l);
        repeat_in = 4'(r);
        start     = 1'b1;
        if (push) sb.push_back('{edge_no + 1 + 1 + rr*(l+2) + (rr-1)*2, l + 2, rr});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) expect_eq(tag, 1, 0);
    endtask

    initial begin
        int e0, n;
        @(negedge clk);
        expect_eq("rst_tmr_rst_n", int'(tmr_rst_n), 0);
        expect_eq("rst_tmr_limit", int'(tmr_limit), 0);
        expect_eq("rst_busy", int'(busy), 0);
        expect_eq("rst_done", int'(done), 0);
        expect_eq("rst_err", int'(err), 0);
        expect_eq("rst_run_cnt", int'(run_cnt), 0);
        expect_eq("rst_last_cyc", int'(last_cyc), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_seq(5, 1, 1);
        wait_idle("wait_l5r1", 50);
        start_seq(5, 3, 1);
        expect_eq("tmr_limit_l5", int'(tmr_limit), 5);
        wait_idle("wait_l5r3", 100);
        start_seq(0, 0, 1);
        wait_idle("wait_l0r0", 50);
        start_seq(255, 1, 1);
        wait_idle("wait_l255", 400);
        repeat (2) @(negedge clk);

        // Abort during the second run
        start_seq(20, 2, 0);
        n = 0;
        while (run_cnt != 4'd1 && n < 100) begin @(negedge clk); n++; end
        expect_eq("abort_first_run_done", int'(run_cnt), 1);
        repeat (6) @(negedge clk);
        expect_eq("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        expect_eq("abort_busy", int'(busy), 0);
        expect_eq("abort_tmr_rst_n", int'(tmr_rst_n), 0);
        expect_eq("abort_run_cnt", int'(run_cnt), 1);
        expect_eq("abort_last_cyc", int'(last_cyc), 22);
        repeat (30) @(negedge clk);

        // Abort and Start together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        expect_eq("abort_start_idle", int'(busy), 0);

        // Timeout with Int stuck low
        force_low = 1'b1;
        e0 = edge_no + 1;
        start_seq(10, 1, 0);
        wait_idle("wait_timeout", 400);
        expect_eq("timeout_edges", edge_no - e0, 261);
        expect_eq("timeout_err", int'(err), 1);
        expect_eq("timeout_run_cnt", int'(run_cnt), 0);
        expect_eq("timeout_tmr_rst_n", int'(tmr_rst_n), 0);
        force_low = 1'b0;
        @(negedge clk);
        start_seq(3, 1, 1);
        expect_eq("err_cleared", int'(err), 0);
        wait_idle("wait_after_err", 50);

        // Start held high while Limit_in changes
        limit_in  = 8'd4;
        repeat_in = 4'd2;
        start     = 1'b1;
        sb.push_back('{edge_no + 1 + 15, 6, 2});
        @(negedge clk);
        limit_in = 8'd99;
        repeat_in = 4'd9;
        repeat (5) @(negedge clk);
        expect_eq("held_tmr_limit", int'(tmr_limit), 4);
        wait_idle("wait_held", 50);
        start = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("held_single_seq", int'(busy), 0);

        // Asynchronous reset mid-sequence
        start_seq(50, 1, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("midrst_busy", int'(busy), 0);
        expect_eq("midrst_tmr_rst_n", int'(tmr_rst_n), 0);
        expect_eq("midrst_tmr_limit", int'(tmr_limit), 0);
        expect_eq("midrst_last_cyc", int'(last_cyc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        expect_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
